// File: rtl/pll_reconfig_seq_if.sv
// ==========================================================================
// pll_reconfig_seq_if : Avalon-MM write port toward the pll_cfg block
// Revision 1.0
// ==========================================================================
`default_nettype none

interface pll_reconfig_seq_if;
  logic [5:0]  mgmt_address;
  logic [31:0] mgmt_writedata;
  logic        mgmt_write;
  logic        mgmt_waitrequest;

  modport master (
    output mgmt_address,
    output mgmt_writedata,
    output mgmt_write,
    input  mgmt_waitrequest
  );

  modport slave (
    input  mgmt_address,
    input  mgmt_writedata,
    input  mgmt_write,
    output mgmt_waitrequest
  );
endinterface

`default_nettype wire

// File: rtl/pll_reconfig_seq.sv
// ==========================================================================
// pll_reconfig_seq : writes the PLL config table, pulses PLL reset, waits lock
// Revision 1.0
// ==========================================================================
`default_nettype none

module pll_reconfig_seq #(
  parameter int GAP          = 7,
  parameter int RST_CYCLES   = 8,
  parameter int SETTLE       = 1024,
  parameter int LOCK_TIMEOUT = 5000000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [31:0]        m_val,
  input  logic [31:0]        k_val,
  input  logic [31:0]        c0_val,
  pll_reconfig_seq_if.master mgmt,
  output logic               pll_reset,
  input  logic               locked,
  output logic               busy,
  output logic               done,
  output logic               lock_err,
  output logic               hold_reset
);
  localparam int GW = $clog2(GAP) + 1;
  localparam int RW = $clog2(RST_CYCLES) + 1;
  localparam int SW = $clog2(SETTLE) + 1;
  localparam int TW = $clog2(LOCK_TIMEOUT) + 1;
  localparam logic [2:0] LAST_IDX = 3'd7;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WRITE     = 3'd1,
    S_GAP_WAIT  = 3'd2,
    S_PRST      = 3'd3,
    S_WAIT_LOCK = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  logic [31:0]   m_q, m_d, k_q, k_d, c0_q, c0_d;
  logic [31:0]   pm_q, pm_d, pk_q, pk_d, pc0_q, pc0_d;
  logic          pend_q, pend_d;
  logic [GW-1:0] gap_cnt_q, gap_cnt_d;
  logic [RW-1:0] rst_cnt_q, rst_cnt_d;
  logic [SW-1:0] settle_cnt_q, settle_cnt_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          meta_q, meta_d, lock_s_q, lock_s_d;
  logic          write_q, write_d;
  logic [5:0]    addr_q, addr_d;
  logic [31:0]   data_q, data_d;
  logic          pll_reset_q, pll_reset_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          lock_err_q, lock_err_d;
  logic          hold_q, hold_d;
  logic          seq_end, seq_ok;
  logic [31:0]   nm, nk, nc0;

  function automatic logic [37:0] table_entry(input logic [2:0] i, input logic [31:0] m,
                                              input logic [31:0] k, input logic [31:0] c0);
    logic [37:0] e;
    e = '0;
    case (i)
      3'd0: e = {6'd0, 32'd0};
      3'd1: e = {6'd4, m};
      3'd2: e = {6'd7, k};
      3'd3: e = {6'd3, 32'h0001_0000};
      3'd4: e = {6'd5, c0};
      3'd5: e = {6'd9, 32'd1};
      3'd6: e = {6'd8, 32'd7};
      3'd7: e = {6'd2, 32'd0};
    endcase
    return e;
  endfunction

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    m_d          = m_q;
    k_d          = k_q;
    c0_d         = c0_q;
    pm_d         = pm_q;
    pk_d         = pk_q;
    pc0_d        = pc0_q;
    pend_d       = pend_q;
    gap_cnt_d    = gap_cnt_q;
    rst_cnt_d    = rst_cnt_q;
    settle_cnt_d = settle_cnt_q;
    to_cnt_d     = to_cnt_q;
    meta_d       = locked;
    lock_s_d     = meta_q;
    write_d      = 1'b0;
    addr_d       = addr_q;
    data_d       = data_q;
    pll_reset_d  = 1'b0;
    busy_d       = busy_q;
    done_d       = 1'b0;
    lock_err_d   = lock_err_q;
    hold_d       = hold_q;
    seq_end      = 1'b0;
    seq_ok       = 1'b0;
    nm           = pm_q;
    nk           = pk_q;
    nc0          = pc0_q;

    // A request during a running sequence is parked; the last one wins.
    if (start && state_q != S_IDLE) begin
      pend_d     = 1'b1;
      pm_d       = m_val;
      pk_d       = k_val;
      pc0_d      = c0_val;
      lock_err_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          m_d              = m_val;
          k_d              = k_val;
          c0_d             = c0_val;
          lock_err_d       = 1'b0;
          hold_d           = 1'b1;
          busy_d           = 1'b1;
          idx_d            = 3'd0;
          state_d          = S_WRITE;
          write_d          = 1'b1;
          {addr_d, data_d} = table_entry(3'd0, m_val, k_val, c0_val);
        end
      end
      S_WRITE: begin
        if (mgmt.mgmt_waitrequest) begin
          write_d = 1'b1;
        end else begin
          state_d   = S_GAP_WAIT;
          gap_cnt_d = '0;
        end
      end
      S_GAP_WAIT: begin
        if (gap_cnt_q == GW'(GAP - 1)) begin
          if (idx_q != LAST_IDX) begin
            idx_d            = idx_q + 3'd1;
            state_d          = S_WRITE;
            write_d          = 1'b1;
            {addr_d, data_d} = table_entry(idx_q + 3'd1, m_q, k_q, c0_q);
          end else begin
            state_d     = S_PRST;
            pll_reset_d = 1'b1;
            rst_cnt_d   = '0;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GW'(1);
        end
      end
      S_PRST: begin
        if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
          state_d      = S_WAIT_LOCK;
          settle_cnt_d = '0;
          to_cnt_d     = '0;
        end else begin
          pll_reset_d = 1'b1;
          rst_cnt_d   = rst_cnt_q + RW'(1);
        end
      end
      S_WAIT_LOCK: begin
        settle_cnt_d = lock_s_q ? settle_cnt_q + SW'(1) : '0;
        to_cnt_d     = to_cnt_q + TW'(1);
        // Settling wins if both terminal counts land in the same cycle.
        if (lock_s_q && settle_cnt_q == SW'(SETTLE - 1)) begin
          seq_end = 1'b1;
          seq_ok  = 1'b1;
        end else if (to_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
          seq_end    = 1'b1;
          lock_err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (seq_end) begin
      if (pend_q || start) begin
        nm               = start ? m_val : pm_q;
        nk               = start ? k_val : pk_q;
        nc0              = start ? c0_val : pc0_q;
        m_d              = nm;
        k_d              = nk;
        c0_d             = nc0;
        pend_d           = 1'b0;
        idx_d            = 3'd0;
        state_d          = S_WRITE;
        write_d          = 1'b1;
        {addr_d, data_d} = table_entry(3'd0, nm, nk, nc0);
      end else begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = seq_ok;
        if (seq_ok) begin
          hold_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      m_q          <= '0;
      k_q          <= '0;
      c0_q         <= '0;
      pm_q         <= '0;
      pk_q         <= '0;
      pc0_q        <= '0;
      pend_q       <= 1'b0;
      gap_cnt_q    <= '0;
      rst_cnt_q    <= '0;
      settle_cnt_q <= '0;
      to_cnt_q     <= '0;
      meta_q       <= 1'b0;
      lock_s_q     <= 1'b0;
      write_q      <= 1'b0;
      addr_q       <= '0;
      data_q       <= '0;
      pll_reset_q  <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      lock_err_q   <= 1'b0;
      hold_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      m_q          <= m_d;
      k_q          <= k_d;
      c0_q         <= c0_d;
      pm_q         <= pm_d;
      pk_q         <= pk_d;
      pc0_q        <= pc0_d;
      pend_q       <= pend_d;
      gap_cnt_q    <= gap_cnt_d;
      rst_cnt_q    <= rst_cnt_d;
      settle_cnt_q <= settle_cnt_d;
      to_cnt_q     <= to_cnt_d;
      meta_q       <= meta_d;
      lock_s_q     <= lock_s_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      pll_reset_q  <= pll_reset_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      lock_err_q   <= lock_err_d;
      hold_q       <= hold_d;
    end
  end

  assign mgmt.mgmt_write     = write_q;
  assign mgmt.mgmt_address   = addr_q;
  assign mgmt.mgmt_writedata = data_q;
  assign pll_reset           = pll_reset_q;
  assign busy                = busy_q;
  assign done                = done_q;
  assign lock_err            = lock_err_q;
  assign hold_reset          = hold_q;

endmodule

`default_nettype wire

// File: tb/tb_pll_reconfig_seq.sv
// ==========================================================================
// tb_pll_reconfig_seq : scoreboard bench for the PLL reconfiguration sequencer
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_pll_reconfig_seq;
  localparam int GAP          = 7;
  localparam int RST_CYCLES   = 8;
  localparam int SETTLE       = 4;
  localparam int LOCK_TIMEOUT = 100;
  localparam int K_WR = 0, K_PR = 1, K_PF = 2, K_DN = 3, K_ER = 4;

  typedef struct {
    int          kind;
    int          cyc;
    logic [5:0]  a;
    logic [31:0] d;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] m_val = '0, k_val = '0, c0_val = '0;
  logic        locked = 1'b1;
  logic        pll_reset, busy, done, lock_err, hold_reset;

  pll_reconfig_seq_if mif();

  pll_reconfig_seq #(
    .GAP(GAP), .RST_CYCLES(RST_CYCLES), .SETTLE(SETTLE), .LOCK_TIMEOUT(LOCK_TIMEOUT)
  ) u_dut (
    .clk(clk), .reset(rst), .start(start), .m_val(m_val), .k_val(k_val), .c0_val(c0_val),
    .mgmt(mif), .pll_reset(pll_reset), .locked(locked), .busy(busy), .done(done),
    .lock_err(lock_err), .hold_reset(hold_reset)
  );

  int   cyc = 0;
  int   n_cmp = 0, n_fail = 0;
  int   obs_wr = 0, n_done = 0;
  ev_t  exp_q[$];
  int   wr_wait[16];
  int   wr_cnt = 0, wbase = 0, left = 0;
  bit   in_wr = 1'b0;
  bit   lock_en = 1'b1;
  int   lo_a = 0, lo_b = 0;
  logic pr_prev = 1'b0, le_prev = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // PLL lock as seen at the pin in a given cycle (optional low window)
  function automatic bit lk(input int c);
    return lock_en && !(c >= lo_a && c < lo_b);
  endfunction

  // pll_cfg responder: stalls write number i for wr_wait[i] cycles
  always @(posedge clk) begin
    #1;
    locked = lk(cyc);
    if (rst) begin
      in_wr = 1'b0; left = 0; mif.mgmt_waitrequest = 1'b0;
    end else if (mif.mgmt_write) begin
      if (!in_wr) begin in_wr = 1'b1; left = wr_wait[wr_cnt % 16]; end
      if (left > 0) begin mif.mgmt_waitrequest = 1'b1; left--; end
      else begin mif.mgmt_waitrequest = 1'b0; in_wr = 1'b0; wr_cnt++; end
    end else begin
      mif.mgmt_waitrequest = 1'b0;
    end
  end

  task automatic push(input int kind, input int c, input logic [5:0] a, input logic [31:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.a = a; e.d = d;
    exp_q.push_back(e);
  endtask

  // Reference: start sampled in cycle s; e returns the cycle done (or lock_err) would appear
  task automatic model_seq(input int s, input logic [31:0] m, input logic [31:0] k,
                           input logic [31:0] c0, input bit sup, output int e);
    logic [5:0]  adr [8];
    logic [31:0] dat [8];
    int t, w, run;
    bit ok;
    adr = '{6'd0, 6'd4, 6'd7, 6'd3, 6'd5, 6'd9, 6'd8, 6'd2};
    dat = '{32'd0, m, k, 32'h10000, c0, 32'd1, 32'd7, 32'd0};
    t = s + 1;
    for (int n = 0; n < 8; n++) begin
      push(K_WR, t + wr_wait[wbase + n], adr[n], dat[n]);
      t = t + wr_wait[wbase + n] + 1 + GAP;
    end
    wbase += 8;
    push(K_PR, t, 6'd0, 32'd0);
    push(K_PF, t + RST_CYCLES, 6'd0, 32'd0);
    w = t + RST_CYCLES;
    run = 0; ok = 1'b0; e = w + LOCK_TIMEOUT;
    for (int c = w; c < w + LOCK_TIMEOUT; c++) begin
      run = lk(c - 2) ? run + 1 : 0;
      if (run == SETTLE) begin ok = 1'b1; e = c + 1; break; end
    end
    if (!ok) push(K_ER, e, 6'd0, 32'd0);
    else if (!sup) push(K_DN, e, 6'd0, 32'd0);
  endtask

  task automatic check_ev(input int kind, input string nm, input bit aux_ok);
    ev_t h;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: event %0d seen at cycle %0d, expected none", nm, kind, cyc);
    end else begin
      h = exp_q.pop_front();
      if (h.kind != kind || h.cyc != cyc || !aux_ok) begin
        n_fail++;
        $display("FAIL %s: got event %0d at cycle %0d (side outputs ok=%0b), expected event %0d at cycle %0d",
                 nm, kind, cyc, aux_ok, h.kind, h.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t h;
    if (rst) begin
      pr_prev = 1'b0; le_prev = 1'b0;
    end else begin
      if (mif.mgmt_write) begin
        if (exp_q.size() == 0 || exp_q[0].kind != K_WR) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_write: cycle %0d addr %0d data %h, expected no write",
                   cyc, mif.mgmt_address, mif.mgmt_writedata);
          if (!mif.mgmt_waitrequest) obs_wr++;
        end else if (mif.mgmt_waitrequest) begin
          n_cmp++;
          if (mif.mgmt_address != exp_q[0].a || mif.mgmt_writedata != exp_q[0].d) begin
            n_fail++;
            $display("FAIL wr_hold: cycle %0d got addr %0d data %h, expected addr %0d data %h",
                     cyc, mif.mgmt_address, mif.mgmt_writedata, exp_q[0].a, exp_q[0].d);
          end
        end else begin
          h = exp_q.pop_front(); obs_wr++; n_cmp++;
          if (h.cyc != cyc || mif.mgmt_address != h.a || mif.mgmt_writedata != h.d) begin
            n_fail++;
            $display("FAIL write: got cycle %0d addr %0d data %h, expected cycle %0d addr %0d data %h",
                     cyc, mif.mgmt_address, mif.mgmt_writedata, h.cyc, h.a, h.d);
          end
        end
      end
      if (pll_reset && !pr_prev) check_ev(K_PR, "prst_rise", 1'b1);
      if (!pll_reset && pr_prev) check_ev(K_PF, "prst_fall", 1'b1);
      if (done) begin n_done++; check_ev(K_DN, "done", !busy && !hold_reset); end
      if (lock_err && !le_prev) check_ev(K_ER, "lock_err", !busy && hold_reset && !done);
      pr_prev = pll_reset; le_prev = lock_err;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Called just after a posedge; start is seen by the DUT in cycle s
  task automatic issue(input logic [31:0] m, input logic [31:0] k, input logic [31:0] c0, output int s);
    start = 1'b1; m_val = m; k_val = k; c0_val = c0; s = cyc;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_cyc(input int x);
    for (int i = 0; i < 5000 && cyc < x; i++) begin @(posedge clk); #1; end
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while (exp_q.size() != 0 && i < budget) begin @(posedge clk); #1; i++; end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events outstanding (head kind %0d cycle %0d), expected 0",
               exp_q.size(), exp_q[0].kind, exp_q[0].cyc);
      exp_q.delete();
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic new_test();
    foreach (wr_wait[i]) wr_wait[i] = 0;
    wr_cnt = 0; wbase = 0; lo_a = 0; lo_b = 0; lock_en = 1'b1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, s2, e, e2, w0, d0;
    logic [31:0] m, k, c0;
    new_test();
    mif.mgmt_waitrequest = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("rst_write", {31'd0, mif.mgmt_write}, 32'd0);
    chk("rst_addr", {26'd0, mif.mgmt_address}, 32'd0);
    chk("rst_data", mif.mgmt_writedata, 32'd0);
    chk("rst_flags", {28'd0, pll_reset, busy, done, lock_err}, 32'd0);
    chk("rst_hold", {31'd0, hold_reset}, 32'd1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic sequence
    new_test();
    issue(32'h00404, 32'hA3D709E8, 32'h20201, s);
    model_seq(s, 32'h00404, 32'hA3D709E8, 32'h20201, 1'b0, e);
    chk("basic_busy_c1", {31'd0, busy}, 32'd1);
    chk("basic_hold_c1", {31'd0, hold_reset}, 32'd1);
    drain(300);
    chk("basic_end_flags", {29'd0, busy, hold_reset, lock_err}, 32'd0);

    // Waitrequest hold on the K write
    new_test();
    wr_wait[2] = 3;
    m = $urandom; k = $urandom; c0 = $urandom;
    issue(m, k, c0, s);
    model_seq(s, m, k, c0, 1'b0, e);
    drain(300);

    // Lock timeout, then a fresh start clears lock_err
    new_test();
    lock_en = 1'b0;
    issue(32'h11, 32'h22, 32'h33, s);
    model_seq(s, 32'h11, 32'h22, 32'h33, 1'b0, e);
    drain(400);
    chk("to_flags", {29'd0, busy, hold_reset, lock_err}, 32'b011);
    lock_en = 1'b1;
    issue(32'h44, 32'h55, 32'h66, s);
    chk("to_clear_err", {31'd0, lock_err}, 32'd0);
    model_seq(s, 32'h44, 32'h55, 32'h66, 1'b0, e);
    drain(300);

    // One-cycle lock glitch after three settled cycles
    new_test();
    issue(32'h77, 32'h88, 32'h99, s);
    lo_a = s + 74; lo_b = s + 75;
    model_seq(s, 32'h77, 32'h88, 32'h99, 1'b0, e);
    drain(300);

    // Restart while busy
    new_test();
    d0 = n_done;
    issue(32'h00404, 32'h1234, 32'h5678, s);
    model_seq(s, 32'h00404, 32'h1234, 32'h5678, 1'b1, e);
    wait_cyc(s + 20);
    k = $urandom; c0 = $urandom;
    issue(32'h00505, k, c0, s2);
    model_seq(e - 1, 32'h00505, k, c0, 1'b0, e2);
    wait_cyc(e);
    chk("restart_busy", {30'd0, busy, hold_reset}, 32'b11);
    drain(400);
    chk("restart_done_count", n_done - d0, 32'd1);

    // Reset in the middle of the C0 write
    new_test();
    issue(32'hAA, 32'hBB, 32'hCC, s);
    model_seq(s, 32'hAA, 32'hBB, 32'hCC, 1'b0, e);
    wait_cyc(s + 33);
    #2;
    rst = 1'b1;
    #1;
    chk("mrst_write", {31'd0, mif.mgmt_write}, 32'd0);
    chk("mrst_busy_hold", {30'd0, busy, hold_reset}, 32'b01);
    exp_q.delete();
    w0 = obs_wr;
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    chk("mrst_no_writes", obs_wr - w0, 32'd0);
    chk("mrst_idle", {30'd0, busy, hold_reset}, 32'b01);

    // Randomized sequences
    for (int trial = 0; trial < 5; trial++) begin
      new_test();
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) wr_wait[i] = $urandom_range(0, 3);
      m = $urandom; k = $urandom; c0 = $urandom;
      issue(m, k, c0, s);
      lo_a = s + $urandom_range(70, 100);
      lo_b = lo_a + $urandom_range(1, 3);
      model_seq(s, m, k, c0, 1'b0, e);
      drain(500);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/pll_reconfig_seq.md
# pll_reconfig_seq

Sequencer for the SDRAM-clock PLL reconfiguration port, which sits between the frequency-step/keyboard logic and the `pll_cfg` management interface. On each request it writes the M, K, N, C0, charge-pump and bandwidth registers with full Avalon-MM waitrequest handshaking, then applies them and pulses the PLL reset. It waits for stable lock and holds the memory tester in reset until the new clock is valid. It reports completion, or a lock timeout.

## Interface
Parameters:
- `GAP`, 7: idle cycles after every completed management write.
- `RST_CYCLES`, 8: width of the `pll_reset` pulse, in cycles.
- `SETTLE`, 1024: consecutive synchronized-locked cycles required before completion.
- `LOCK_TIMEOUT`, 5000000: maximum cycles spent waiting for lock (100 ms at 50 MHz).

Ports:
- `clk` in 1: management clock (CLK_50M domain).
- `reset` in 1: asynchronous, active-high.
- `start` in 1: single-cycle request to reconfigure.
- `m_val`, `k_val`, `c0_val` in 32 each: register values, sampled in the cycle `start`=1.
- `mgmt_address` out 6, `mgmt_writedata` out 32, `mgmt_write` out 1: write to `pll_cfg`.
- `mgmt_waitrequest` in 1: from `pll_cfg`.
- `pll_reset` out 1: to the PLL `rst` input.
- `locked` in 1: PLL lock output, asynchronous to `clk`.
- `busy` out 1: a sequence is in progress.
- `done` out 1: one-cycle pulse on successful completion.
- `lock_err` out 1: sticky flag, set on timeout, cleared by the next `start`.
- `hold_reset` out 1: active-high reset to the memory tester.

## Operation
- States: IDLE, WRITE, GAP_WAIT, PRST, WAIT_LOCK.
- Write table, issued in this order (address, data):
  - (0, 0)
  - (4, M)
  - (7, K)
  - (3, 'h10000)
  - (5, C0)
  - (9, 1)
  - (8, 7)
  - (2, 0), the apply write.
- A 3-bit index selects the table entry.
- IDLE: on `start`, latch `m_val`/`k_val`/`c0_val`, clear `lock_err`, set index to 0 and go to WRITE.
- WRITE: drive `mgmt_write`=1 with the indexed address and data.
  - Hold `mgmt_write`, address and data stable while `mgmt_waitrequest`=1.
  - A write completes on the edge where `mgmt_write`=1 and `mgmt_waitrequest`=0; then go to GAP_WAIT.
  - `mgmt_write` is 0 in every other state.
  - There is no waitrequest timeout.
- GAP_WAIT: count `GAP` cycles.
  - If the index is below 7: increment the index and return to WRITE.
  - Otherwise go to PRST.
- PRST: `pll_reset`=1 for exactly `RST_CYCLES` cycles, then go to WAIT_LOCK.
- WAIT_LOCK: pass `locked` through a 2-flop synchronizer to give `locked_s`.
  - A consecutive-high counter resets whenever `locked_s`=0.
  - When the counter reaches `SETTLE`: pulse `done`, deassert `hold_reset`, go to IDLE.
  - The timeout counter starts at 0 on entry. If it reaches `LOCK_TIMEOUT` first: set `lock_err`, go to IDLE, and keep `hold_reset`=1.
- `busy`=1 in every state except IDLE.
- `hold_reset` is set to 1 on `start` and stays 1 until a successful completion.
- `start` while busy:
  - Latch the new values into a pending slot and set the pending flag. The last request wins.
  - The current sequence is never aborted.
  - At the end of the current sequence (success or timeout), suppress `done`, clear the pending flag and go straight to WRITE with index 0 using the pending values.
  - `busy` stays 1 throughout.
  - A `start` coinciding with the end-of-sequence cycle counts as pending.
- Outside IDLE, if `locked_s` falls while `hold_reset`=0, nothing happens; lock loss is reported only during WAIT_LOCK.
- Counter widths are sized by `$clog2` of each parameter plus 1. No counter wraps; each saturates at its terminal compare.

## Timing
- Reset values:
  - `mgmt_write`=0, `mgmt_address`=0, `mgmt_writedata`=0.
  - `pll_reset`=0, `busy`=0, `done`=0, `lock_err`=0.
  - `hold_reset`=1; state IDLE; pending flag 0.
- Reset asserted mid-sequence: all of the above apply immediately, including `mgmt_write`=0. The caller must issue a new `start`.
- `start` in IDLE at cycle 0 gives `mgmt_write`=1 and `busy`=1 in cycle 1.
- With `mgmt_waitrequest`=0 throughout, write n (0..7) occupies cycle 1+n·(GAP+1).
- With the defaults:
  - The apply write is at cycle 57.
  - `pll_reset`=1 during cycles 65–72.
  - WAIT_LOCK begins at cycle 73.
- Each waitrequest cycle delays all later events by one cycle.
- `locked` reaches `locked_s` after 2 cycles.
- `done` asserts in the cycle after the SETTLE-th consecutive `locked_s`=1 sample, together with `busy`=0 and `hold_reset`=0.
- All outputs are registered.

## Test plan
- **Basic sequence.** `GAP`=7, `RST_CYCLES`=8, `SETTLE`=4; `locked`=1 and `mgmt_waitrequest`=0 throughout; `start` at cycle 0 with M='h00404, K='hA3D709E8, C0='h20201.
  - Writes (0,0), (4,'h404), (7,'hA3D709E8), (3,'h10000), (5,'h20201), (9,1), (8,7), (2,0) at cycles 1, 9, …, 57.
  - `pll_reset` high cycles 65–72.
  - `done` at cycle 77.
  - `hold_reset` falls at cycle 77.
- **Waitrequest hold.** Hold `mgmt_waitrequest`=1 for 3 cycles on the K write.
  - Address 7 and data stay stable for 4 cycles with `mgmt_write`=1.
  - All later events shift by 3 cycles.
- **Lock timeout.** `LOCK_TIMEOUT`=100, `locked`=0.
  - `lock_err`=1 after 100 WAIT_LOCK cycles.
  - `done` never pulses; `hold_reset` stays 1; `busy` returns to 0.
  - A second `start` clears `lock_err`.
- **Lock glitch.** `locked` drops for 1 cycle after 3 high cycles in WAIT_LOCK.
  - The settle counter restarts.
  - `done` arrives 4 cycles after `locked_s` returns high.
- **Restart while busy.** A second `start` with M='h00505 at cycle 20.
  - The first sequence completes without a `done` pulse.
  - It is followed immediately by a full second write sequence with (4,'h505).
  - Exactly one `done` pulse in total.
- **Reset mid-sequence.** Assert `reset` during the C0 write.
  - `mgmt_write`=0, `busy`=0 and `hold_reset`=1 asynchronously.
  - No further writes until the next `start`.
